// File: rtl/detrans_pkg.sv
// Shared types and helpers for the bit-plane de-transposer.
package detrans_pkg;

   localparam int unsigned PREC_W = 5;
   localparam int unsigned PIDX_W = 4;

   localparam logic [PREC_W-1:0] PREC_2  = 5'd2;
   localparam logic [PREC_W-1:0] PREC_4  = 5'd4;
   localparam logic [PREC_W-1:0] PREC_8  = 5'd8;
   localparam logic [PREC_W-1:0] PREC_16 = 5'd16;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_ISSUE = 2'd1,
      RD_DRAIN = 2'd2,
      EMIT     = 2'd3
   } state_e;

   typedef struct packed {
      logic              valid;
      logic [PIDX_W-1:0] idx;
   } rd_tag_t;

   function automatic logic prec_supported(input logic [31:0] p);
      return (p == 32'd2) || (p == 32'd4) || (p == 32'd8) || (p == 32'd16);
   endfunction

   function automatic logic [2:0] prec_lg2(input logic [PREC_W-1:0] p);
      case (p)
         PREC_2:  return 3'd1;
         PREC_4:  return 3'd2;
         PREC_8:  return 3'd3;
         PREC_16: return 3'd4;
         default: return 3'd2;
      endcase
   endfunction

   // Output words per job and elements per word for a supported precision.
   function automatic int unsigned calc_nout(input logic [PREC_W-1:0] p,
                                             input int unsigned nw, input int unsigned xlen);
      return (nw * 32'(p)) / xlen;
   endfunction

   function automatic int unsigned calc_elems(input logic [PREC_W-1:0] p, input int unsigned xlen);
      return xlen / 32'(p);
   endfunction

endpackage

// File: rtl/detrans_rd_pipe.sv
// Tracks outstanding MVU RAM reads: RD_LAT-deep shift of {valid, plane index}.
module detrans_rd_pipe
   import detrans_pkg::*;
#(
   parameter int unsigned RD_LAT = 2
) (
   input  logic    clk,
   input  logic    rst_n,
   input  rd_tag_t tag_i,
   output rd_tag_t tag_o
);

   rd_tag_t stage_q [RD_LAT];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= tag_i;
         for (int i = 1; i < RD_LAT; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign tag_o = stage_q[RD_LAT-1];

endmodule

// File: rtl/data_detransposer.sv
// Repacks MVU bit-plane words into element-packed XLEN words.
// Optional DETRANS_ERR_EN: reject unsupported precision with a one-cycle err pulse.
module data_detransposer
   import detrans_pkg::*;
#(
   parameter int unsigned NUM_WORDS     = 64,
   parameter int unsigned XLEN          = 32,
   parameter int unsigned MVU_ADDR_LEN  = 32,
   parameter int unsigned MVU_DATA_LEN  = 64,
   parameter int unsigned MAX_DATA_PREC = 16,
   parameter int unsigned RD_LAT        = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [31:0]             prec,
   input  logic [31:0]             baddr,
   input  logic                    start,
   output logic                    busy,
   output logic                    mvu_rd_en,
   output logic [MVU_ADDR_LEN-1:0] mvu_rd_addr,
   input  logic [MVU_DATA_LEN-1:0] mvu_rd_word,
   output logic                    ovalid,
   input  logic                    oready,
   output logic [XLEN-1:0]         oword,
`ifdef DETRANS_ERR_EN
   output logic                    err,
`endif
   output logic                    olast
);

   localparam int unsigned EL_W   = $clog2(NUM_WORDS);
   localparam int unsigned BP_W   = $clog2(NUM_WORDS * MAX_DATA_PREC);
   localparam int unsigned OIDX_W = $clog2(NUM_WORDS * MAX_DATA_PREC / XLEN);

   state_e                  state_q, state_d;
   logic [PREC_W-1:0]       prec_q, prec_d;
   logic [2:0]              lg_q, lg_d;
   logic [PIDX_W-1:0]       issue_q, issue_d;
   logic [PREC_W-1:0]       cap_q, cap_d;
   logic [OIDX_W-1:0]       oidx_q, oidx_d;
   logic [OIDX_W-1:0]       last_idx_q, last_idx_d;
   logic                    busy_q, busy_d;
   logic                    rd_en_q, rd_en_d;
   logic [MVU_ADDR_LEN-1:0] rd_addr_q, rd_addr_d;
   logic                    ovalid_q, ovalid_d;
   logic [XLEN-1:0]         oword_q, oword_d;
   logic                    olast_q, olast_d;
   logic                    err_q, err_d;

   logic [MVU_DATA_LEN-1:0] plane_q [MAX_DATA_PREC];
   logic                    plane_clr_c;
   logic                    accept_c;
   logic                    reject_c;
   logic [PREC_W-1:0]       sel_prec_c;
   logic [XLEN-1:0]         word_c;
   logic [BP_W-1:0]         bp_c;
   logic [PIDX_W-1:0]       pb_c;
   logic [EL_W-1:0]         el_c;
   rd_tag_t                 tag_in, tag_out;

   assign tag_in = '{valid: rd_en_q, idx: issue_q};

   detrans_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .tag_i (tag_in),
      .tag_o (tag_out)
   );

`ifdef DETRANS_ERR_EN
   assign accept_c   = start & prec_supported(prec);
   assign reject_c   = start & ~prec_supported(prec);
   assign sel_prec_c = prec[PREC_W-1:0];
`else
   assign accept_c   = start;
   assign reject_c   = 1'b0;
   assign sel_prec_c = prec_supported(prec) ? prec[PREC_W-1:0] : PREC_4;
`endif

   // Output bit i of word oidx: element = flat bit / prec, plane = flat bit % prec.
   always_comb begin
      word_c = '0;
      bp_c   = '0;
      pb_c   = '0;
      el_c   = '0;
      for (int i = 0; i < XLEN; i++) begin
         bp_c      = BP_W'(oidx_q) * BP_W'(XLEN) + BP_W'(i);
         pb_c      = PIDX_W'(bp_c & BP_W'(prec_q - 5'd1));
         el_c      = EL_W'(bp_c >> lg_q);
         word_c[i] = plane_q[pb_c][EL_W'(NUM_WORDS-1) - el_c];
      end
   end

   always_comb begin
      state_d     = state_q;
      prec_d      = prec_q;
      lg_d        = lg_q;
      issue_d     = issue_q;
      cap_d       = cap_q;
      oidx_d      = oidx_q;
      last_idx_d  = last_idx_q;
      busy_d      = busy_q;
      rd_en_d     = rd_en_q;
      rd_addr_d   = rd_addr_q;
      ovalid_d    = ovalid_q;
      oword_d     = oword_q;
      olast_d     = olast_q;
      err_d       = 1'b0;
      plane_clr_c = 1'b0;

      if (tag_out.valid) cap_d = cap_q + PREC_W'(1);

      case (state_q)
         IDLE: begin
            err_d = reject_c;
            if (accept_c) begin
               state_d     = RD_ISSUE;
               prec_d      = sel_prec_c;
               lg_d        = prec_lg2(sel_prec_c);
               last_idx_d  = OIDX_W'(calc_nout(sel_prec_c, NUM_WORDS, XLEN) - 32'd1);
               busy_d      = 1'b1;
               rd_en_d     = 1'b1;
               rd_addr_d   = MVU_ADDR_LEN'(baddr);
               issue_d     = '0;
               cap_d       = '0;
               oidx_d      = '0;
               plane_clr_c = 1'b1;
            end
         end
         RD_ISSUE: begin
            if (issue_q == PIDX_W'(prec_q - 5'd1)) begin
               rd_en_d = 1'b0;
               state_d = RD_DRAIN;
            end else begin
               issue_d   = issue_q + PIDX_W'(1);
               rd_addr_d = rd_addr_q + MVU_ADDR_LEN'(1);
            end
         end
         RD_DRAIN: begin
            if (cap_q == prec_q) begin
               state_d  = EMIT;
               ovalid_d = 1'b1;
               oword_d  = word_c;
               olast_d  = (oidx_q == last_idx_q);
               oidx_d   = oidx_q + OIDX_W'(1);
            end
         end
         EMIT: begin
            if (ovalid_q && oready) begin
               if (olast_q) begin
                  ovalid_d = 1'b0;
                  olast_d  = 1'b0;
                  busy_d   = 1'b0;
                  state_d  = IDLE;
               end else begin
                  oword_d = word_c;
                  olast_d = (oidx_q == last_idx_q);
                  oidx_d  = oidx_q + OIDX_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         prec_q     <= PREC_4;
         lg_q       <= 3'd2;
         issue_q    <= '0;
         cap_q      <= '0;
         oidx_q     <= '0;
         last_idx_q <= '0;
         busy_q     <= 1'b0;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         ovalid_q   <= 1'b0;
         oword_q    <= '0;
         olast_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         prec_q     <= prec_d;
         lg_q       <= lg_d;
         issue_q    <= issue_d;
         cap_q      <= cap_d;
         oidx_q     <= oidx_d;
         last_idx_q <= last_idx_d;
         busy_q     <= busy_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
         ovalid_q   <= ovalid_d;
         oword_q    <= oword_d;
         olast_q    <= olast_d;
         err_q      <= err_d;
      end
   end

   // Plane buffer: cleared when a job is accepted, filled as reads return.
   always_ff @(posedge clk) begin
      if (plane_clr_c) begin
         for (int b = 0; b < MAX_DATA_PREC; b++) plane_q[b] <= '0;
      end else if (tag_out.valid) begin
         plane_q[tag_out.idx] <= mvu_rd_word;
      end
   end

   assign busy        = busy_q;
   assign mvu_rd_en   = rd_en_q;
   assign mvu_rd_addr = rd_addr_q;
   assign ovalid      = ovalid_q;
   assign oword       = oword_q;
   assign olast       = olast_q;
`ifdef DETRANS_ERR_EN
   assign err         = err_q;
`else
   logic unused_err;
   assign unused_err = err_q ^ reject_c;
`endif

endmodule

// File: tb/tb_data_detransposer.sv
// Scoreboard bench for data_detransposer: element-level reference model, decoupled monitor.
module tb_data_detransposer;

   localparam int unsigned NUM_WORDS = 64;
   localparam int unsigned XLEN      = 32;
   localparam int unsigned RD_LAT    = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] prec = 32'd0;
   logic [31:0] baddr = 32'd0;
   logic        start = 1'b0;
   logic        busy;
   logic        mvu_rd_en;
   logic [31:0] mvu_rd_addr;
   logic [63:0] mvu_rd_word;
   logic        ovalid;
   logic        oready = 1'b0;
   logic [31:0] oword;
   logic        olast;
`ifdef DETRANS_ERR_EN
   logic        err;
`endif

   data_detransposer dut (
      .clk(clk), .rst_n(rst_n), .prec(prec), .baddr(baddr), .start(start), .busy(busy),
      .mvu_rd_en(mvu_rd_en), .mvu_rd_addr(mvu_rd_addr), .mvu_rd_word(mvu_rd_word),
      .ovalid(ovalid), .oready(oready), .oword(oword),
`ifdef DETRANS_ERR_EN
      .err(err),
`endif
      .olast(olast)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic last; logic [31:0] w; } exp_t;

   exp_t        exp_q [$];
   logic [31:0] rd_exp_q [$];
   int          errors = 0;
   int          checks = 0;
   int          hs_total = 0;
   int          ready_mode = 0;
   int          stall_base = 0;
   logic [63:0] mem [logic [31:0]];
   logic [63:0] planes [16];

   // RAM model: data for a read issued in cycle c is presented in cycle c+RD_LAT.
   logic [RD_LAT-1:0] rp_v = '0;
   logic [63:0]       rp_d [RD_LAT];
   always @(posedge clk) begin
      rp_v[0] <= mvu_rd_en;
      rp_d[0] <= mem.exists(mvu_rd_addr) ? mem[mvu_rd_addr] : 64'd0;
      for (int i = 1; i < RD_LAT; i++) begin
         rp_v[i] <= rp_v[i-1];
         rp_d[i] <= rp_d[i-1];
      end
   end
   assign mvu_rd_word = rp_v[RD_LAT-1] ? rp_d[RD_LAT-1] : 64'hDEAD_BEEF_0BAD_F00D;

   function automatic void chk(input bit ok, input string name, input logic [63:0] act,
                               input logic [63:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endfunction

   function automatic int eff_prec(input int p);
      if (p == 2 || p == 4 || p == 8 || p == 16) return p;
      return 4;
   endfunction

   // Reference: build integer elements, then pack E of them per word, low slot first.
   function automatic void model_job(input int p, input logic [31:0] base);
      int   nout, e_per;
      logic [15:0] elem [NUM_WORDS];
      exp_t x;
      mem.delete();
      for (int b = 0; b < p; b++) begin
         mem[base + 32'(b)] = planes[b];
         rd_exp_q.push_back(base + 32'(b));
      end
      for (int e = 0; e < NUM_WORDS; e++) begin
         elem[e] = '0;
         for (int b = 0; b < p; b++) elem[e][b] = planes[b][NUM_WORDS-1-e];
      end
      nout  = NUM_WORDS * p / XLEN;
      e_per = XLEN / p;
      for (int k = 0; k < nout; k++) begin
         x.w = '0;
         for (int j = 0; j < e_per; j++) x.w = x.w | (32'(elem[k*e_per+j]) << (j*p));
         x.last = (k == nout - 1);
         exp_q.push_back(x);
      end
   endfunction

   task automatic monitor();
      bit          stall_prev = 0;
      logic [31:0] w_prev = '0;
      logic        l_prev = 0;
      exp_t        x;
      logic [31:0] a;
      forever begin
         @(negedge clk);
         if (mvu_rd_en) begin
            if (rd_exp_q.size() == 0) chk(0, "rd_unexpected", mvu_rd_addr, 0);
            else begin
               a = rd_exp_q.pop_front();
               chk(mvu_rd_addr == a, "rd_addr", mvu_rd_addr, a);
            end
         end
         if (stall_prev)
            chk(ovalid && oword == w_prev && olast == l_prev, "stall_hold",
                {ovalid, olast, oword}, {1'b1, l_prev, w_prev});
         if (ovalid && oready) begin
            hs_total++;
            if (exp_q.size() == 0) chk(0, "out_unexpected", oword, 0);
            else begin
               x = exp_q.pop_front();
               chk(oword == x.w, "oword", oword, x.w);
               chk(olast == x.last, "olast", olast, x.last);
            end
         end
         stall_prev = ovalid && !oready && rst_n;
         w_prev     = oword;
         l_prev     = olast;
      end
   endtask

   task automatic ready_proc();
      int stall_n = 0;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0: oready = 1'b1;
            1: oready = ($urandom_range(0, 3) != 0);
            2: begin
               oready = !((hs_total - stall_base) == 2 && stall_n < 3);
               if (!oready) stall_n++;
            end
            default: oready = 1'b0;
         endcase
         if (ready_mode != 2) stall_n = 0;
      end
   endtask

   // Issues start at a posedge+1 and returns one cycle after the accept edge; optional latency check.
   task automatic start_job(input logic [31:0] p, input logic [31:0] base, input bit chk_lat);
      int n;
      @(posedge clk); #1;
      prec = p; baddr = base; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (chk_lat) begin
         chk(busy == 1'b1, "busy_after_start", busy, 1);
         n = 0;
         while (!ovalid && n < 100) begin
            @(posedge clk); #1;
            n++;
         end
         chk(n == eff_prec(int'(p)) + RD_LAT + 1, "first_ovalid_cycle", n,
             eff_prec(int'(p)) + RD_LAT + 1);
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
         @(posedge clk);
         n++;
      end
      chk(n < 5000, "job_timeout", n, 5000);
      #1;
      chk(!busy && !ovalid, "idle_after_last", {busy, ovalid}, 0);
      chk(rd_exp_q.size() == 0, "reads_missing", rd_exp_q.size(), 0);
   endtask

   initial begin
      exp_t x;
      int   base_hs;
      fork
         monitor();
         ready_proc();
      join_none

      repeat (3) @(posedge clk);
      #1;
      chk({busy, mvu_rd_en, ovalid, olast} == 4'b0, "reset_ctrl", {busy, mvu_rd_en, ovalid, olast}, 0);
      chk(oword == 0 && mvu_rd_addr == 0, "reset_data", {oword, mvu_rd_addr}, 0);
      rst_n = 1'b1;

      // prec=2 directed: even elements = 1, odd = 0.
      planes[0] = 64'hAAAA_AAAA_AAAA_AAAA; planes[1] = 64'h0;
      mem.delete();
      mem[32'h100] = planes[0]; mem[32'h101] = planes[1];
      rd_exp_q.push_back(32'h100); rd_exp_q.push_back(32'h101);
      for (int k = 0; k < 4; k++) begin
         x.w = 32'h1111_1111; x.last = (k == 3); exp_q.push_back(x);
      end
      ready_mode = 0;
      start_job(32'd2, 32'h100, 1);
      wait_done();

      // prec=8 directed: plane 7 ones -> every element 0x80.
      for (int b = 0; b < 16; b++) planes[b] = 64'h0;
      planes[7] = '1;
      mem.delete();
      for (int b = 0; b < 8; b++) begin
         mem[32'h2000 + 32'(b)] = planes[b];
         rd_exp_q.push_back(32'h2000 + 32'(b));
      end
      for (int k = 0; k < 16; k++) begin
         x.w = 32'h8080_8080; x.last = (k == 15); exp_q.push_back(x);
      end
      start_job(32'd8, 32'h2000, 1);
      wait_done();

      // prec=16 with 3-cycle stall on word 2.
      for (int b = 0; b < 16; b++) planes[b] = {$urandom, $urandom};
      model_job(16, 32'h3000);
      stall_base = hs_total;
      ready_mode = 2;
      start_job(32'd16, 32'h3000, 1);
      wait_done();
      chk(hs_total - stall_base == 32, "p16_word_count", hs_total - stall_base, 32);

      // start pulsed during EMIT must be ignored.
      for (int b = 0; b < 16; b++) planes[b] = {$urandom, $urandom};
      model_job(4, 32'h4000);
      ready_mode = 1;
      start_job(32'd4, 32'h4000, 1);
      #1 prec = 32'd16; baddr = 32'h9000; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done();
      repeat (20) @(posedge clk);
      #1 chk(!busy && !ovalid && exp_q.size() == 0, "start_ignored", {busy, ovalid}, 0);

      // Reset in the middle of EMIT, then a clean prec=4 job.
      for (int b = 0; b < 16; b++) planes[b] = {$urandom, $urandom};
      model_job(4, 32'h5000);
      ready_mode = 3;
      start_job(32'd4, 32'h5000, 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      chk({busy, mvu_rd_en, ovalid, olast} == 4'b0, "midreset_ctrl", {busy, mvu_rd_en, ovalid, olast}, 0);
      chk(oword == 0 && mvu_rd_addr == 0, "midreset_data", {oword, mvu_rd_addr}, 0);
      rst_n = 1'b1;
      exp_q.delete(); rd_exp_q.delete();
      for (int b = 0; b < 16; b++) planes[b] = {$urandom, $urandom};
      model_job(4, 32'h5100);
      base_hs = hs_total;
      ready_mode = 0;
      start_job(32'd4, 32'h5100, 1);
      wait_done();
      chk(hs_total - base_hs == 8, "post_reset_words", hs_total - base_hs, 8);

      // Unsupported precision.
      for (int b = 0; b < 16; b++) planes[b] = {$urandom, $urandom};
`ifdef DETRANS_ERR_EN
      mem.delete();
      start_job(32'd3, 32'h6000, 0);
      chk(err == 1'b1 && busy == 1'b0, "err_pulse", {err, busy}, 2'b10);
      @(posedge clk); #1;
      chk(err == 1'b0, "err_one_cycle", err, 0);
      repeat (10) @(posedge clk);
      #1 chk(!busy && !ovalid, "err_stays_idle", {busy, ovalid}, 0);
`else
      model_job(eff_prec(3), 32'h6000);
      base_hs = hs_total;
      start_job(32'd3, 32'h6000, 1);
      wait_done();
      chk(hs_total - base_hs == 8, "prec3_as_4_words", hs_total - base_hs, 8);
`endif

      // Random jobs, random backpressure, including address wrap.
      ready_mode = 1;
      for (int t = 0; t < 8; t++) begin
         int          p;
         logic [31:0] base;
         p    = 2 << $urandom_range(0, 3);
         base = (t == 0) ? 32'hFFFF_FFFD : $urandom;
         for (int b = 0; b < 16; b++) planes[b] = {$urandom, $urandom};
         model_job(p, base);
         start_job(32'(p), base, 1);
         wait_done();
      end

      repeat (5) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
